// File: rtl/mem_ctrl_if.sv
// Core-side memory port bundle for mem_ctrl.
// Two read ports (0: instruction fetch, 1: data load) packed 32 bits per port in the
// 64-bit address/data vectors and 2 bits per port in the length vector. One write port.
// Lengths encode byte count minus one. Each ack is a one-cycle pulse.
//   master: the core (drives requests, receives data/acks)
//   slave : mem_ctrl (receives requests, drives data/acks)
interface mem_ctrl_if;
    logic [63:0] co_raddr;
    logic [1:0]  co_re;
    logic [3:0]  co_rlen;
    logic [63:0] co_din;
    logic [1:0]  co_rack;
    logic [31:0] co_waddr;
    logic [31:0] co_dout;
    logic        co_we;
    logic [1:0]  co_wlen;
    logic        co_wack;

    modport master (
        output co_raddr, co_re, co_rlen, co_waddr, co_dout, co_we, co_wlen,
        input  co_din, co_rack, co_wack
    );

    modport slave (
        input  co_raddr, co_re, co_rlen, co_waddr, co_dout, co_we, co_wlen,
        output co_din, co_rack, co_wack
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the core's two read ports and one write port onto a byte-wide
// synchronous RAM (read data one cycle after address), moving 1-4 bytes little-endian
// per request and pulsing a one-cycle ack when the transfer completes.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   co                core request/ack bundle (mem_ctrl_if.slave)
//   mem_a             RAM byte address (ADDR_W bits, wraps modulo 2^ADDR_W)
//   mem_wdata, mem_wr RAM write byte and strobe
//   mem_rdata         RAM read byte
// Build option: define MEM_CTRL_RR_EN for round-robin between the read ports (write still
// wins); otherwise fixed priority write > read 1 > read 0.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    mem_ctrl_if.slave         co,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_wdata,
    output logic              mem_wr,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StAck} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        len_q;
    logic [31:0]       wdata_q;
    logic [1:0]        port_q;   // 0/1 read port, 2 write port
    logic [2:0]        cnt_q;
    logic [31:0]       res_q;
    logic              cool_q;   // high only in the IDLE cycle right after an ACK
    logic [63:0]       din_q;
    logic [1:0]        rack_q;
    logic              wack_q;
    logic [ADDR_W-1:0] mem_a_q;
    logic [7:0]        mem_wdata_q;
    logic              mem_wr_q;
`ifdef MEM_CTRL_RR_EN
    logic              rr_q;     // read port preferred when both are pending
`endif

    assign co.co_din  = din_q;
    assign co.co_rack = rack_q;
    assign co.co_wack = wack_q;
    assign mem_a      = mem_a_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wr     = mem_wr_q;

    // Address bits above ADDR_W are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{co.co_raddr, co.co_waddr};

    // Eligibility: {write, read1, read0}, minus the port that was just acked.
    logic [2:0] elig;
    always_comb begin
        elig = {co.co_we, co.co_re};
        if (cool_q) begin
            elig[port_q] = 1'b0;
        end
    end

    logic gnt_wr;
    logic gnt_rd;
    logic gnt_port;
    always_comb begin
        gnt_wr   = elig[2];
        gnt_rd   = 1'b0;
        gnt_port = 1'b0;
        if (!elig[2]) begin
`ifdef MEM_CTRL_RR_EN
            if (elig[1] && elig[0]) begin
                gnt_rd   = 1'b1;
                gnt_port = rr_q;
            end else if (elig[1]) begin
                gnt_rd   = 1'b1;
                gnt_port = 1'b1;
            end else if (elig[0]) begin
                gnt_rd   = 1'b1;
                gnt_port = 1'b0;
            end
`else
            if (elig[1]) begin
                gnt_rd   = 1'b1;
                gnt_port = 1'b1;
            end else if (elig[0]) begin
                gnt_rd   = 1'b1;
                gnt_port = 1'b0;
            end
`endif
        end
    end

    logic [ADDR_W-1:0] rsel_addr;
    logic [1:0]        rsel_len;
    assign rsel_addr = gnt_port ? co.co_raddr[32 +: ADDR_W] : co.co_raddr[ADDR_W-1:0];
    assign rsel_len  = gnt_port ? co.co_rlen[3:2] : co.co_rlen[1:0];

    // In RD cycle cnt_q (>=1) the RAM returns the byte addressed one cycle earlier.
    logic [31:0] res_d;
    always_comb begin
        res_d = res_q;
        case (cnt_q)
            3'd1:    res_d[7:0]   = mem_rdata;
            3'd2:    res_d[15:8]  = mem_rdata;
            3'd3:    res_d[23:16] = mem_rdata;
            3'd4:    res_d[31:24] = mem_rdata;
            default: ;
        endcase
    end

    logic [2:0]        cnt_inc;
    logic [ADDR_W-1:0] addr_nxt;
    logic [31:0]       wshift;
    assign cnt_inc  = cnt_q + 3'd1;
    assign addr_nxt = addr_q + ADDR_W'(cnt_inc);
    assign wshift   = wdata_q >> {cnt_inc, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            port_q      <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            cool_q      <= 1'b0;
            din_q       <= '0;
            rack_q      <= '0;
            wack_q      <= 1'b0;
            mem_a_q     <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
`ifdef MEM_CTRL_RR_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            cool_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (gnt_wr) begin
                        addr_q      <= co.co_waddr[ADDR_W-1:0];
                        len_q       <= co.co_wlen;
                        wdata_q     <= co.co_dout;
                        port_q      <= 2'd2;
                        cnt_q       <= '0;
                        mem_a_q     <= co.co_waddr[ADDR_W-1:0];
                        mem_wdata_q <= co.co_dout[7:0];
                        mem_wr_q    <= 1'b1;
                        state_q     <= StWr;
                    end else if (gnt_rd) begin
                        addr_q  <= rsel_addr;
                        len_q   <= rsel_len;
                        port_q  <= {1'b0, gnt_port};
                        cnt_q   <= '0;
                        res_q   <= '0;
                        mem_a_q <= rsel_addr;
                        state_q <= StRd;
`ifdef MEM_CTRL_RR_EN
                        rr_q    <= ~gnt_port;
`endif
                    end
                end
                StRd: begin
                    res_q <= res_d;
                    cnt_q <= cnt_inc;
                    if (cnt_q < {1'b0, len_q}) begin
                        mem_a_q <= addr_nxt;
                    end
                    if (cnt_q == {1'b0, len_q} + 3'd1) begin
                        rack_q[port_q[0]] <= 1'b1;
                        if (port_q[0]) begin
                            din_q[63:32] <= res_d;
                        end else begin
                            din_q[31:0] <= res_d;
                        end
                        state_q <= StAck;
                    end
                end
                StWr: begin
                    if (cnt_q == {1'b0, len_q}) begin
                        mem_wr_q <= 1'b0;
                        wack_q   <= 1'b1;
                        state_q  <= StAck;
                    end else begin
                        cnt_q       <= cnt_inc;
                        mem_a_q     <= addr_nxt;
                        mem_wdata_q <= wshift[7:0];
                    end
                end
                StAck: begin
                    rack_q  <= '0;
                    wack_q  <= 1'b0;
                    cool_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory-side responder for the core's request/acknowledge memory interface. It accepts the core's two read ports (port 0 instruction fetch, port 1 data load) and its single write port (data store). It arbitrates them onto one byte-wide synchronous RAM, assembles or splits 1–4 byte transfers little-endian, and returns a one-cycle acknowledge per completed request. It sits between the core's memory ports and the board RAM.

## Interface
- ADDR_W, 17, RAM byte-address width; request addresses are truncated to their low ADDR_W bits.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- co_raddr  in  64  read addresses; port p occupies bits [32p+31:32p].
- co_re  in  2  read requests, one bit per port.
- co_rlen  in  4  read lengths; port p occupies bits [2p+1:2p]; byte count = len+1.
- co_din  out  64  read data; port p occupies bits [32p+31:32p].
- co_rack  out  2  read acknowledges, one bit per port.
- co_waddr  in  32  write address.
- co_dout  in  32  write data, little-endian, low bytes first.
- co_we  in  1  write request.
- co_wlen  in  2  write length; byte count = len+1.
- co_wack  out  1  write acknowledge.
- mem_a  out  ADDR_W  RAM byte address.
- mem_wdata  out  8  RAM write byte.
- mem_wr  out  1  RAM write strobe.
- mem_rdata  in  8  RAM read byte; valid one cycle after its address.

## Operation
- Request rule: the requester holds re/we, address, length and data stable until it sees its ack. It deasserts the request the cycle after the ack.
- States: IDLE, RD, WR, ACK.
- IDLE: samples requests and grants one according to the arbitration policy. It latches the address, length, data and port id.
  - Write grant goes to WR.
  - Read grant goes to RD.
  - No request stays in IDLE.
- RD: byte counter k runs 0..len.
  - Each cycle drives mem_a = addr+k.
  - On each later cycle, captures mem_rdata into byte k of the result register.
  - After the last byte is captured, goes to ACK.
- WR: for k = 0..len, drives mem_a = addr+k, mem_wdata = byte k of the data, mem_wr = 1. After the final byte, goes to ACK.
- ACK:
  - For a read, pulses co_rack[port] for one cycle.
  - For a write, pulses co_wack for one cycle.
  - Then returns to IDLE.
- Read data: co_din[port] holds the assembled word, with unfetched upper bytes zero. It is valid in the ack cycle and stays held until that port's next ack.
- Address arithmetic is modulo 2^ADDR_W; a transfer crossing the top address wraps to 0.
- Cooldown: a port that was acked is not eligible for a grant in the cycle immediately after its ack, even if its request line is still high.
- No request is ever dropped. An ungranted request stays pending until it is served.

## Timing
- Reset values:
  - State is IDLE.
  - co_rack = 0, co_wack = 0, co_din = 0.
  - mem_a = 0, mem_wdata = 0, mem_wr = 0.
  - The round-robin pointer selects port 0 first.
- Grant is decided in cycle 0, the IDLE cycle in which the request is sampled.
- Read of N = len+1 bytes:
  - Addresses are issued in cycles 1..N.
  - Bytes are captured in cycles 2..N+1.
  - Ack is in cycle N+2.
  - A 4-byte read takes 6 cycles from request to ack.
- Write of N bytes:
  - mem_wr is high in cycles 1..N.
  - Ack is in cycle N+1.
  - A 4-byte write takes 5 cycles.
- mem_wr is never high outside WR.
- Back-to-back transfers: after an ACK cycle, the next grant is decided in the following IDLE cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. The others wait; their latency grows by the full service time of each transfer ahead of them.
- rst mid-transfer:
  - Aborts immediately to the reset state with no ack.
  - A partially written RAM range is left as written.
  - The requester must reissue.

## Configuration
- MEM_CTRL_RR_EN defined:
  - The write port keeps absolute priority.
  - Between the two read ports, a round-robin pointer decides. When both are pending, the port not served last wins; the pointer updates on each read grant.
- MEM_CTRL_RR_EN undefined: fixed priority, with write first, then read port 1, then read port 0.

## Test plan
- Single read: RAM[0x100..0x103] = 11,22,33,44, port 0 reads len=3 at 0x100.
  - co_rack[0] pulses once, 6 cycles after the request.
  - co_din[31:0] = 0x44332211.
- Short reads: port 1 reads len=0 at 0x101, then len=1 at 0x102.
  - First returns 0x00000022 with ack at cycle 3.
  - Second returns 0x00004433 with ack at cycle 4.
- Write then read: co_dout = 0xDEADBEEF, len=3 at 0x200; then port 1 reads len=3 at 0x200.
  - mem_wr is high for exactly 4 cycles.
  - co_wack pulses at cycle 5.
  - The read returns 0xDEADBEEF.
- Contention: we, re[1] and re[0] all asserted in the same cycle, each len=3.
  - Acks arrive in order wack, rack[1], rack[0] without MEM_CTRL_RR_EN.
  - With MEM_CTRL_RR_EN, when reads repeat continuously, rack[0] and rack[1] alternate.
- Wrap-around: with ADDR_W=17, 4-byte read at 0x1FFFE. mem_a sequence is 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- Reset and hold: assert rst in cycle 2 of a 4-byte read.
  - All outputs return to 0 asynchronously and no ack is produced.
  - Holding re[0] high after release yields a fresh, correct 6-cycle read.
  - A request held one cycle past its ack is not served twice.
